// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
// Latency: pure wiring, no state.
// Backpressure: none; every signal is meaningful every cycle.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_btb;
  logic [15:0] hit_count;

  // Core side: drives fetch PC and resolved branches, consumes predictions.
  modport master (
    output fetch_pc, upd_en, upd_pc, upd_is_jump, upd_taken, upd_target, flush_btb,
    input  pred_taken, pred_target, hit_count
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, upd_en, upd_pc, upd_is_jump, upd_taken, upd_target, flush_btb,
    output pred_taken, pred_target, hit_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Latency: prediction is combinational from fetch_pc; updates visible next cycle.
// Backpressure: none; one lookup and one update are accepted every cycle.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic             vld_q [ENTRIES];
  logic [1:0]       ctr_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [29:0]      tgt_q [ENTRIES];
  logic [15:0]      hit_count_q, hit_count_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, pred_taken;
  logic             u_hit, u_taken_eff, u_act, ctr_we, tag_we, tgt_we;
  logic [1:0]       ctr_cur, ctr_d;

  assign f_idx = bp.fetch_pc[IDX_W+1:2];
  assign f_tag = bp.fetch_pc[31:IDX_W+2];
  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[31:IDX_W+2];

  // Lookup reads pre-update state only; there is deliberately no bypass.
  always_comb begin
    f_hit      = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken = f_hit && ctr_q[f_idx][1];
  end

  assign bp.pred_taken  = pred_taken;
  assign bp.pred_target = pred_taken ? {tgt_q[f_idx], 2'b00} : bp.fetch_pc + 32'd4;
  assign bp.hit_count   = hit_count_q;

  // Training decode: reset and flush both swallow a same-cycle update.
  always_comb begin
    u_act       = bp.upd_en && !bp.flush_btb && !rst;
    u_hit       = vld_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_taken_eff = bp.upd_is_jump || bp.upd_taken;
    ctr_cur     = ctr_q[u_idx];
    ctr_d       = ctr_cur;
    if (u_hit) begin
      if (bp.upd_is_jump)    ctr_d = CTR_ST;
      else if (bp.upd_taken) ctr_d = (ctr_cur == CTR_ST)  ? CTR_ST  : ctr_cur + 2'd1;
      else                   ctr_d = (ctr_cur == CTR_SNT) ? CTR_SNT : ctr_cur - 2'd1;
    end else begin
      ctr_d = bp.upd_is_jump ? CTR_ST : CTR_WT;
    end
    // A miss that was not taken leaves the occupant untouched.
    ctr_we = u_act && (u_hit || u_taken_eff);
    tag_we = u_act && !u_hit && u_taken_eff;
    tgt_we = u_act && u_taken_eff;
  end

  // Saturating count of predicted-taken cycles.
  always_comb begin
    hit_count_d = hit_count_q;
    if (pred_taken && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
  end

  // Valid bits and counters: reset clears valid and parks counters at weak-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld_q[i] <= 1'b0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (bp.flush_btb) begin
      for (int i = 0; i < ENTRIES; i++) vld_q[i] <= 1'b0;
    end else begin
      if (tag_we) vld_q[u_idx] <= 1'b1;
      if (ctr_we) ctr_q[u_idx] <= ctr_d;
    end
  end

  // Tag and target storage carry no reset; they are only meaningful behind valid.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[u_idx] <= u_tag;
    if (tgt_we) tgt_q[u_idx] <= bp.upd_target[31:2];
  end

  // Hit counter: only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) hit_count_q <= 16'd0;
    else     hit_count_q <= hit_count_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp ();
  branch_predictor #(.ENTRIES(16)) dut (.clk(clk), .rst(rst), .bp(bp));

  typedef struct {
    int          cyc;
    logic        pt;
    logic [31:0] tgt;
    logic [15:0] hc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;

  // Reference model: a table of entries keyed by index, integer counters.
  bit          m_vld [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  int          m_hc = 0;

  function automatic void model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int idx = (pc >> 2) % 16;
    bit hit = m_vld[idx] && (m_tag[idx] == (pc >> 6));
    pt  = hit && (m_ctr[idx] >= 2);
    tgt = pt ? m_tgt[idx] : pc + 32'd4;
  endfunction

  // Drive one cycle of stimulus, queue the expected response, advance the model at the edge.
  task automatic cyc(input logic [31:0] fpc, input bit ue, input logic [31:0] upc,
                     input bit uj, input bit ut, input logic [31:0] utg,
                     input bit fl, input bit r, input bit chk);
    logic        pt;
    logic [31:0] tgt;
    exp_t        e;
    int          idx;
    bit          hit, tk;
    bp.fetch_pc = fpc; bp.upd_en = ue; bp.upd_pc = upc; bp.upd_is_jump = uj;
    bp.upd_taken = ut; bp.upd_target = utg; bp.flush_btb = fl; rst = r;
    model_lookup(fpc, pt, tgt);
    if (chk) begin
      e.cyc = cyc_n; e.pt = pt; e.tgt = tgt; e.hc = m_hc[15:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) begin m_vld[i] = 0; m_ctr[i] = 1; end
      m_hc = 0;
    end else begin
      if (pt && m_hc < 65535) m_hc++;
      if (fl) begin
        for (int i = 0; i < 16; i++) m_vld[i] = 0;
      end else if (ue) begin
        idx = (upc >> 2) % 16;
        hit = m_vld[idx] && (m_tag[idx] == (upc >> 6));
        tk  = uj || ut;
        if (hit) begin
          if (uj) m_ctr[idx] = 3;
          else if (ut) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          else m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
          if (tk) m_tgt[idx] = {utg[31:2], 2'b00};
        end else if (tk) begin
          m_vld[idx] = 1; m_tag[idx] = upc >> 6;
          m_tgt[idx] = {utg[31:2], 2'b00};
          m_ctr[idx] = uj ? 3 : 2;
        end
      end
    end
    cyc_n++;
    #1;
  endtask

  task automatic look(input logic [31:0] fpc);
    cyc(fpc, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: the predictor answers every cycle, so pop one expectation per sampled cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (bp.pred_taken !== e.pt) begin
        fails++;
        $display("FAIL pred_taken cyc=%0d got=%0b exp=%0b", e.cyc, bp.pred_taken, e.pt);
      end
      tests++;
      if (bp.pred_target !== e.tgt) begin
        fails++;
        $display("FAIL pred_target cyc=%0d got=%08h exp=%08h", e.cyc, bp.pred_target, e.tgt);
      end
      tests++;
      if (bp.hit_count !== e.hc) begin
        fails++;
        $display("FAIL hit_count cyc=%0d got=%04h exp=%04h", e.cyc, bp.hit_count, e.hc);
      end
    end
  end

  initial begin
    logic [31:0] pc, up;
    for (int i = 0; i < 16; i++) begin m_vld[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0; end
    // Reset: state is unknown before the first edge, so only check once it has been cleared.
    cyc(32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 1, 1);
    look(32'h100);

    // Counter walk on 0x100.
    cyc(32'h200, 1, 32'h100, 0, 1, 32'h80, 0, 0, 1);
    cyc(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 1);
    look(32'h100);

    // Alias: jump at 0x140 evicts 0x100.
    cyc(32'h0, 1, 32'h100, 0, 1, 32'h80, 0, 0, 1);
    cyc(32'h0, 1, 32'h140, 1, 0, 32'h200, 0, 0, 1);
    look(32'h100);
    look(32'h140);

    // Same-cycle lookup and allocating update: old contents seen.
    cyc(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 0, 1);
    look(32'h100);

    // Flush beats a simultaneous update.
    cyc(32'h100, 1, 32'h300, 0, 1, 32'h400, 1, 0, 1);
    look(32'h100);
    look(32'h300);
    look(32'hFFFF_FFFC);

    // Randomized traffic over a few indices and tags to force hits and aliasing.
    for (int i = 0; i < 3000; i++) begin
      pc = {20'h0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom)};
      up = {20'h0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      cyc(pc, $urandom_range(0, 1), up, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          $urandom, ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0), 1);
    end

    // Saturation of hit_count under a held predicted-taken PC.
    cyc(32'h0, 1, 32'h140, 1, 0, 32'h200, 0, 0, 1);
    for (int i = 0; i < 70000; i++)
      cyc(32'h140, 0, 0, 0, 0, 0, 0, 0, (i % 5000 == 0) || (i >= 69995));
    look(32'hFFFF_FFFC);
    look(32'h140);

    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry. It sits beside the fetch stage. Each cycle it gives a same-cycle taken/target prediction for the fetch PC. It is trained by resolved branches and jumps reported from execute. Counter states use the core's branch prediction encoding: STRONG_NOT_TAKEN=00, WEAK_NOT_TAKEN=01, WEAK_TAKEN=10, STRONG_TAKEN=11.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 2..256
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- fetch_pc  in  32  PC being fetched (word_t)
- pred_taken  out  1  predict taken for fetch_pc
- pred_target  out  32  next-PC prediction
- upd_en  in  1  a resolved control-flow instruction is reported this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_is_jump  in  1  1 = JAL/JALR (unconditional), 0 = conditional BTYPE
- upd_taken  in  1  actual outcome; ignored (treated as 1) when upd_is_jump=1
- upd_target  in  32  actual target address
- flush_btb  in  1  invalidate all entries (fence/CSR-driven)
- hit_count  out  16  number of cycles with fetch_pc hit and pred_taken=1; saturating

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target[31:2] and counter (2 bits). target[1:0] reads back as 00.
- **Lookup (combinational from fetch_pc and current state):**
  - hit = valid & (tag matches).
  - pred_taken = hit & counter[1].
  - pred_target = stored target if pred_taken, else fetch_pc+4 (32-bit wrap: 0xFFFFFFFC+4 = 0).
- **Update on upd_en=1 (applied at the clock edge):**
  - Hit, conditional: taken increments the counter, saturating at 11. Not-taken decrements it, saturating at 00. Target is written only when taken.
  - Hit, jump: counter becomes 11 and target is written.
  - Miss, taken conditional: allocate the entry (overwrite any occupant). Set valid=1, tag, target, counter=10.
  - Miss, jump: allocate with counter=11.
  - Miss, not-taken conditional: no change.
- flush_btb=1 clears every valid bit at the edge. It takes priority over a simultaneous upd_en, whose update is dropped.
- hit_count increments by 1 per cycle in which pred_taken=1 and stays at 0xFFFF once reached. flush_btb does not clear it; only rst does.

## Timing
- Prediction latency is 0 cycles: pred_* is combinational from fetch_pc.
- An update becomes visible to lookups the cycle after the upd_en edge.
- Same cycle, same index for lookup and update: the lookup returns the old (pre-update) contents. There is no bypass.
- Reset (rst=1 at an edge) clears all valid bits, sets all counters to 01 and sets hit_count=0.
  - The lookup logic still runs during reset, so pred_taken=0 and pred_target=fetch_pc+4 while state is cleared.
  - Reset asserted while upd_en=1 drops the update.
- Tag and target storage need no reset. Valid, counter and hit_count must be reset.
- A flush has the same single-cycle effect on valid bits as reset. Counters keep their values but are unreachable until the entry is reallocated, and reallocation overwrites the counter.
- No stall or backpressure: the block accepts one update and serves one lookup every cycle.

## Test plan
- Reset, then fetch_pc=0x100 → pred_taken=0, pred_target=0x104, hit_count=0.
- Conditional taken update at upd_pc=0x100, target 0x80; next cycle fetch_pc=0x100 → pred_taken=1, pred_target=0x80. Second taken update, then three not-taken updates → counter walks 10→11→10→01→00; pred_taken=0 from the third not-taken onward.
- Alias with ENTRIES=16: allocate at 0x100, then a jump update at 0x140 (same index, different tag) to target 0x200 → fetch 0x100 misses (pred_target=0x104); fetch 0x140 gives pred_taken=1, pred_target=0x200.
- Same-cycle lookup and update at 0x100 (miss → allocate) → that cycle pred_taken=0; the following cycle pred_taken=1.
- flush_btb with simultaneous upd_en at 0x300 → both 0x100 and 0x300 miss next cycle; hit_count is unchanged.
- Hold a predicted-taken fetch_pc for 70000 cycles → hit_count saturates at 0xFFFF. fetch_pc=0xFFFFFFFC on a miss → pred_target=0x00000000.
